// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Redirect targets are word-aligned by dropping the low two bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus, single outstanding request.
interface fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with load-target / increment / hold controls.
module fetch_pc_reg import fetch_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // PC update; load has priority over increment, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= align_word(target);
    end else if (inc) begin
      pc <= pc_plus4;
    end
  end

  // Wraps naturally at 2^32.
  always_comb begin
    pc_plus4 = pc + 32'd4;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned instruction for the IF/ID register.
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallF,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_if.master       imem,
  output logic [31:0]   InstrF,
  output logic [31:0]   PCF,
  output logic [31:0]   PCPlus4F,
  output logic          ValidF,
  output logic          FetchBusyF
);

  fetch_state_t state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  instr_q, instr_d;
  logic         pc_load, pc_inc, capture;

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .inc     (pc_inc),
    .target  (PCTargetE),
    .pc      (PCF),
    .pc_plus4(PCPlus4F)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect always beats a same-cycle response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_REQ: begin
        if (!PCSrcE && imem.ready) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem.rvalid) state_d = (kill_q || PCSrcE) ? FS_REQ : FS_HOLD;
      end
      FS_HOLD: begin
        if (PCSrcE || !StallF) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
  end

  // Output and datapath control decode.
  always_comb begin
    imem.req = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    capture  = 1'b0;
    kill_d   = kill_q;
    unique case (state_q)
      FS_REQ: begin
        // Dropping req on a redirect lets the address change legally.
        imem.req = !PCSrcE && !reset;
        pc_load  = PCSrcE;
      end
      FS_WAIT: begin
        pc_load = PCSrcE;
        if (imem.rvalid) begin
          capture = !kill_q && !PCSrcE;
          kill_d  = 1'b0;
        end else if (PCSrcE) begin
          // Response still owed for the old PC; drop it when it arrives.
          kill_d = 1'b1;
        end
      end
      FS_HOLD: begin
        pc_load = PCSrcE;
        pc_inc  = !PCSrcE && !StallF;
      end
      default: ;
    endcase
    instr_d    = capture ? imem.rdata : instr_q;
    imem.addr  = PCF;
    ValidF     = (state_q == FS_HOLD);
    FetchBusyF = !ValidF;
    InstrF     = ValidF ? instr_q : NOP_INSTR;
  end

  // Kill flag and captured instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_q  <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      kill_q  <= kill_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the hazard-aware pipelined RISC-V core, directly upstream of the IF/ID pipeline register. It owns the PC register and issues one instruction-memory request at a time over a ready/valid handshake, so memory latency may vary. It presents `InstrF`/`PCF`/`PCPlus4F` to the IF/ID register and takes stall and redirect control from the hazard unit and execute stage. When no instruction is ready, it signals the hazard unit through `FetchBusyF`.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction driven on `InstrF` when no valid fetch is held (`addi x0,x0,0`).

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `StallF` in 1: hazard unit holds the current fetch; no PC advance.
- `PCSrcE` in 1: execute-stage redirect (taken branch/jump).
- `PCTargetE` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request address, equal to `PCF`.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: response instruction.
- `InstrF` out 32: held instruction, or `NOP_INSTR` when `ValidF`=0.
- `PCF` out 32: PC of the current/held fetch.
- `PCPlus4F` out 32: `PCF`+4, modulo 2^32.
- `ValidF` out 1: `InstrF` holds a real fetched instruction.
- `FetchBusyF` out 1: equals !`ValidF`; the hazard unit uses it to stall or flush decode.

## Operation
- FSM states:
  - REQ: issue the request.
  - WAIT: request accepted, response pending.
  - HOLD: instruction captured and presented.
- REQ:
  - `imem_req` = !`PCSrcE`.
  - If `PCSrcE`: `PC` <= `PCTargetE`, stay in REQ.
  - Else if `imem_ready`: go to WAIT.
  - `imem_addr` must stay stable while `imem_req`=1 and `imem_ready`=0. A redirect drops `imem_req` for that cycle so the address can change.
- WAIT:
  - `imem_req`=0.
  - If `PCSrcE`: `PC` <= `PCTargetE` and set `kill`.
  - On `imem_rvalid` with `kill`=0 (and no `PCSrcE` the same cycle): capture `imem_rdata`, go to HOLD.
  - On `imem_rvalid` with `kill`=1, or with `PCSrcE` the same cycle: discard the data, clear `kill`, go to REQ at the updated `PC`.
  - `PCSrcE` and `imem_rvalid` in the same cycle: the redirect wins and the data is discarded.
- HOLD:
  - `ValidF`=1.
  - `PCSrcE` (has priority over `StallF`): `PC` <= `PCTargetE`, go to REQ, `ValidF` drops next cycle.
  - Else if !`StallF`: `PC` <= `PC`+4, go to REQ.
  - Else stay in HOLD; all outputs are held.
- `StallF` is ignored in REQ and WAIT. No PC change can occur there except a redirect.
- `imem_rvalid` outside WAIT is ignored.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (asynchronous):
  - `PC`=`RESET_VECTOR`, state=REQ, `kill`=0, instruction register=`NOP_INSTR`.
  - `ValidF`=0, `FetchBusyF`=1, `imem_req`=0 while `reset` is high.
  - A response arriving after deassertion is ignored, because the state is REQ.
- Deassertion mid-transaction: the first request is issued in the first cycle after `reset` falls.
- Latency, with `imem_ready` held high and `imem_rvalid` one cycle after acceptance:
  - Request at cycle n, response at n+1, `ValidF`=1 at n+2.
  - Steady-state throughput is one instruction per 3 cycles when `StallF`=0.
- Longer memory latency extends WAIT one cycle per cycle of delay.
- Only one request is ever outstanding.

## Structure
- Shared package `fetch_pkg`: `fetch_state_t` enum {`FS_REQ`, `FS_WAIT`, `FS_HOLD`} and the `NOP_INSTR` constant. The parameter default references the package constant.
- One sub-module, `fetch_pc_reg`:
  - Holds the 32-bit PC with asynchronous reset to `RESET_VECTOR`.
  - Has load-target, increment, and hold controls.
  - Produces `PCPlus4F`.
- The FSM, `kill` flag, and instruction capture register live in `fetch_stage`.

## Test plan
- Reset with `RESET_VECTOR`=32'h0000_1000, always-ready 1-cycle memory returning 32'h00500093:
  - `imem_addr`=32'h1000.
  - `ValidF` rises two cycles after the first request.
  - `InstrF`=32'h00500093, `PCPlus4F`=32'h1004.
  - Next request is to 32'h1004.
- `StallF`=1 for 4 cycles in HOLD: `PCF`, `InstrF`, and `ValidF` are unchanged; no `imem_req` is issued. On release, the next request is to `PCF`+4.
- `PCSrcE`=1 with `PCTargetE`=32'h0000_2003 while in WAIT, and the response arrives 3 cycles later: the response is discarded, `ValidF` stays 0, and the next request is to 32'h2000.
- `PCSrcE` and `StallF` both high in HOLD at `PCF`=32'h40: redirect to `PCTargetE`=32'h80; `ValidF` is 0 the next cycle.
- `imem_ready` held low for 5 cycles: `imem_req` stays 1 and `imem_addr` stays stable; `FetchBusyF`=1 throughout.
- `PC`=32'hFFFF_FFFC: `PCPlus4F`=0; after HOLD releases, the request is to 32'h0000_0000.
